// File: rtl/ex_stage_md_pkg.sv
// Shared encodings for the execute stage: mul/div opcodes, EX/MEM control bit
// positions and ALU function codes.
package ex_stage_md_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMfhi  = 3'd5,
    MdMflo  = 3'd6
  } md_op_e;

  // out_ctl = {mem_to_reg[1:0], reg_write, mem_read, mem_write}
  localparam int unsigned CtlW        = 5;
  localparam int unsigned CtlMemWrite = 0;
  localparam int unsigned CtlMemRead  = 1;
  localparam int unsigned CtlRegWrite = 2;
  localparam int unsigned CtlMemToReg = 3;

  localparam logic [5:0] AluSll = 6'h00;
  localparam logic [5:0] AluSrl = 6'h02;
  localparam logic [5:0] AluSra = 6'h03;
  localparam logic [5:0] AluAdd = 6'h20;
  localparam logic [5:0] AluSub = 6'h22;
  localparam logic [5:0] AluAnd = 6'h24;
  localparam logic [5:0] AluOr  = 6'h25;
  localparam logic [5:0] AluXor = 6'h26;
  localparam logic [5:0] AluNor = 6'h27;
  localparam logic [5:0] AluSlt = 6'h2a;
  localparam logic [5:0] AluEq  = 6'h30;
  localparam logic [5:0] AluNe  = 6'h31;

  // Opcodes that occupy the iterative unit (as opposed to hi/lo reads).
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. Shifts move operand b by a[4:0]; compare ops return 0/1.
module alu
  import ex_stage_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [5:0]      fun,
  input  logic            sign,
  output logic [XLEN-1:0] result
);

  logic [4:0] sh;
  logic       lt;

  // Function decode; sign selects signed or unsigned set-less-than.
  always_comb begin
    sh     = a[4:0];
    lt     = sign ? ($signed(a) < $signed(b)) : (a < b);
    result = '0;
    case (fun)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluNor:  result = ~(a | b);
      AluSlt:  result = {{(XLEN-1){1'b0}}, lt};
      AluSll:  result = b << sh;
      AluSrl:  result = b >> sh;
      AluSra:  result = $signed(b) >>> sh;
      AluEq:   result = {{(XLEN-1){1'b0}}, (a == b)};
      AluNe:   result = {{(XLEN-1){1'b0}}, (a != b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Radix-2 iterative multiply/divide on operand magnitudes, one bit per cycle
// for XLEN cycles. res_hi/res_lo are valid while done is high.
module md_unit
  import ex_stage_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam int unsigned   CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  logic            busy_q, is_div_q, neg_q, neg_rem_q, dz_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] acc_hi_q, acc_lo_q, dvs_q;
  logic [XLEN-1:0] acc_hi_d, acc_lo_d;
  logic            op_div, op_signed, a_neg, b_neg, ge;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   sum, rem_w, diff;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Operand conditioning at start: work on magnitudes, remember result signs.
  always_comb begin
    op_div    = (op == MdDiv) || (op == MdDivu);
    op_signed = (op == MdMult) || (op == MdDiv);
    a_neg     = op_signed & a[XLEN-1];
    b_neg     = op_signed & b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // One iteration: shift-add multiply or restoring-division step.
  always_comb begin
    sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
    rem_w = {acc_hi_q, acc_lo_q[XLEN-1]};
    diff  = rem_w - {1'b0, dvs_q};
    ge    = (rem_w >= {1'b0, dvs_q});
    if (is_div_q) begin
      acc_hi_d = ge ? diff[XLEN-1:0] : rem_w[XLEN-1:0];
      acc_lo_d = {acc_lo_q[XLEN-2:0], ge};
    end else begin
      acc_hi_d = sum[XLEN:1];
      acc_lo_d = {sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up of the final step; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod     = {acc_hi_d, acc_lo_d};
    prod_fix = neg_q ? -prod : prod;
    if (is_div_q) begin
      res_lo = dz_q ? '1 : (neg_q ? -acc_lo_d : acc_lo_d);
      res_hi = neg_rem_q ? -acc_hi_d : acc_hi_d;
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

  // Load operands on start, then iterate until the counter reaches XLEN-1.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      dvs_q     <= '0;
    end else if (busy_q) begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) busy_q <= 1'b0;
    end else if (start) begin
      busy_q    <= 1'b1;
      cnt_q     <= '0;
      is_div_q  <= op_div;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= op_div && (b == '0);
      acc_hi_q  <= '0;
      acc_lo_q  <= op_div ? a_mag : b_mag;
      dvs_q     <= op_div ? b_mag : a_mag;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LastCnt);

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, branch resolve, hi/lo mul/div and
// the registered EX/MEM output with a valid/ready handshake.
module ex_stage_md
  import ex_stage_md_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned MD_EN = 1
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] rt,
  input  logic [RA_W-1:0] wreg,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      shamt,
  input  logic            alu_src1,
  input  logic            alu_src2,
  input  logic            sign,
  input  logic [5:0]      alu_fun,
  input  logic [2:0]      md_op,
  input  logic            branch,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_to_reg,
  input  logic            flush,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            exm_we,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  input  logic            mwb_we,
  output logic            branch_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store,
  output logic [RA_W-1:0] out_wreg,
  output logic [CtlW-1:0] out_ctl,
  output logic            md_busy
);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_result, result_d;
  logic [XLEN-1:0] hi_q, lo_q, md_hi, md_lo;
  logic [CtlW-1:0] ctl_d;
  logic [2:0]      md_op_eff;
  logic            md_iter, accept, md_start, md_done;

  // Forwarding (EX/MEM wins over MEM/WB, register 0 never forwards) and ALU muxes.
  always_comb begin
    if (exm_we && (exm_rd == rs) && (exm_rd != '0))      fwd_a = exm_data;
    else if (mwb_we && (mwb_rd == rs) && (mwb_rd != '0)) fwd_a = mwb_data;
    else                                                 fwd_a = rs_data;
    if (exm_we && (exm_rd == rt) && (exm_rd != '0))      fwd_b = exm_data;
    else if (mwb_we && (mwb_rd == rt) && (mwb_rd != '0)) fwd_b = mwb_data;
    else                                                 fwd_b = rt_data;
    alu_a = alu_src1 ? {{(XLEN-5){1'b0}}, shamt} : fwd_a;
    alu_b = alu_src2 ? imm : fwd_b;
  end

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .fun   (alu_fun),
    .sign  (sign),
    .result(alu_result)
  );

  // Handshake, accept, branch redirect and md start; any md op stalls while busy.
  always_comb begin
    md_op_eff    = (MD_EN != 0) ? md_op : 3'd0;
    md_iter      = is_iter_op(md_op_eff);
    in_ready     = (!out_valid || out_ready) && !(md_busy && (md_op_eff != MdNone));
    accept       = in_valid && in_ready && !flush;
    branch_taken = reset_b && accept && branch && alu_result[0];
    md_start     = accept && md_iter;
  end

  // Payload selection; a taken branch squashes its own side effects.
  always_comb begin
    result_d = alu_result;
    if (md_op_eff == MdMfhi)      result_d = hi_q;
    else if (md_op_eff == MdMflo) result_d = lo_q;
    ctl_d = '0;
    if (!branch_taken) begin
      ctl_d[CtlMemToReg +: 2] = mem_to_reg;
      ctl_d[CtlRegWrite]      = reg_write && !md_iter;
      ctl_d[CtlMemRead]       = mem_read;
      ctl_d[CtlMemWrite]      = mem_write;
    end
  end

  if (MD_EN != 0) begin : g_md
    md_unit #(
      .XLEN(XLEN)
    ) u_md (
      .clk    (clk),
      .reset_b(reset_b),
      .start  (md_start),
      .op     (md_op_eff),
      .a      (fwd_a),
      .b      (fwd_b),
      .busy   (md_busy),
      .done   (md_done),
      .res_hi (md_hi),
      .res_lo (md_lo)
    );
  end else begin : g_no_md
    assign md_busy = 1'b0;
    assign md_done = 1'b0;
    assign md_hi   = '0;
    assign md_lo   = '0;
  end

  // hi/lo capture the unit's result on its final iteration.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end
  end

  // EX/MEM register: load on accept, hold while stalled, drain when consumed.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_store  <= '0;
      out_wreg   <= '0;
      out_ctl    <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= result_d;
      out_store  <= fwd_b;
      out_wreg   <= wreg;
      out_ctl    <= ctl_d;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Randomized bench for ex_stage_md against a cycle-level behavioural model,
// plus directed cases with hand-computed results.
module tb_ex_stage_md;
  import ex_stage_md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        in_valid, in_ready, flush, out_valid, out_ready, branch_taken, md_busy;
  logic [4:0]  rs, rt, wreg, shamt, exm_rd, mwb_rd, out_wreg, out_ctl;
  logic [31:0] rs_data, rt_data, imm, exm_data, mwb_data, out_result, out_store;
  logic        alu_src1, alu_src2, sign, branch, reg_write, mem_read, mem_write;
  logic        exm_we, mwb_we;
  logic [5:0]  alu_fun;
  logic [2:0]  md_op;
  logic [1:0]  mem_to_reg;

  int n_checks = 0;
  int n_fail = 0;

  // Model state
  logic        m_ov;
  logic [31:0] m_res, m_store, m_hi, m_lo, m_pend_hi, m_pend_lo;
  logic [4:0]  m_wreg, m_ctl;
  int          m_busy_left;
  // Per-cycle expectations
  logic        e_ready, e_acc, e_bt;
  logic [31:0] e_alu, e_fb;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(32), .RA_W(5), .MD_EN(1)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .wreg(wreg), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .shamt(shamt), .alu_src1(alu_src1), .alu_src2(alu_src2), .sign(sign),
    .alu_fun(alu_fun), .md_op(md_op), .branch(branch), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .flush(flush),
    .exm_rd(exm_rd), .exm_data(exm_data), .exm_we(exm_we),
    .mwb_rd(mwb_rd), .mwb_data(mwb_data), .mwb_we(mwb_we),
    .branch_taken(branch_taken), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store(out_store), .out_wreg(out_wreg),
    .out_ctl(out_ctl), .md_busy(md_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (exm_we && exm_rd == r && exm_rd != 0) return exm_data;
    if (mwb_we && mwb_rd == r && mwb_rd != 0) return mwb_data;
    return d;
  endfunction

  function automatic logic [31:0] model_alu(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic sg);
    int unsigned sh;
    sh = a % 32;
    case (f)
      AluAdd: return a + b;
      AluSub: return a - b;
      AluAnd: return a & b;
      AluOr:  return a | b;
      AluXor: return a ^ b;
      AluNor: return ~(a | b);
      AluSlt: return sg ? 32'($signed(a) < $signed(b)) : 32'(a < b);
      AluSll: return 32'(longint'(b) * (longint'(1) << sh));
      AluSrl: return b / (32'd1 << sh);
      AluSra: return 32'($signed(b) >>> sh);
      AluEq:  return 32'(a == b);
      AluNe:  return 32'(a != b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
    longint     p;
    logic [63:0] up;
    int         sa, sb;
    sa = a;
    sb = b;
    hi = 0;
    lo = 0;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); {hi, lo} = p; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      3'd3: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      3'd4: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_ov = 0; m_res = 0; m_store = 0; m_wreg = 0; m_ctl = 0;
    m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0; m_busy_left = 0;
  endtask

  // Compare process: expected combinational outputs and register contents.
  task automatic eval_check();
    logic [31:0] fa, aa, bb;
    logic        stall;
    #1;
    fa    = fwd(rs, rs_data);
    e_fb  = fwd(rt, rt_data);
    aa    = alu_src1 ? {27'd0, shamt} : fa;
    bb    = alu_src2 ? imm : e_fb;
    e_alu = model_alu(alu_fun, aa, bb, sign);
    stall = (m_busy_left > 0) && (md_op != 0);
    e_ready = (!m_ov || out_ready) && !stall;
    e_acc = reset_b && in_valid && e_ready && !flush;
    e_bt  = e_acc && branch && e_alu[0];
    check("in_ready", in_ready, e_ready);
    check("branch_taken", branch_taken, e_bt);
    check("md_busy", md_busy, m_busy_left > 0);
    check("out_valid", out_valid, m_ov);
    check("out_result", out_result, m_res);
    check("out_store", out_store, m_store);
    check("out_wreg", out_wreg, m_wreg);
    check("out_ctl", out_ctl, m_ctl);
  endtask

  task automatic advance();
    logic        n_ov;
    logic [31:0] n_res, n_store, n_hi, n_lo, p_hi, p_lo;
    logic [4:0]  n_wreg, n_ctl;
    logic        iter;
    int          n_busy;
    n_ov = m_ov; n_res = m_res; n_store = m_store; n_wreg = m_wreg; n_ctl = m_ctl;
    n_hi = m_hi; n_lo = m_lo; n_busy = m_busy_left; p_hi = m_pend_hi; p_lo = m_pend_lo;
    iter = (md_op >= 1) && (md_op <= 4);
    if (e_acc) begin
      n_ov = 1;
      n_res = (md_op == 5) ? m_hi : (md_op == 6) ? m_lo : e_alu;
      n_store = e_fb;
      n_wreg = wreg;
      n_ctl = e_bt ? 5'd0 : {mem_to_reg, reg_write && !iter, mem_read, mem_write};
    end else if (out_ready) begin
      n_ov = 0;
    end
    if (m_busy_left > 0) begin
      n_busy = m_busy_left - 1;
      if (n_busy == 0) begin n_hi = m_pend_hi; n_lo = m_pend_lo; end
    end
    if (e_acc && iter) begin
      n_busy = 32;
      md_compute(md_op, fwd(rs, rs_data), e_fb, p_hi, p_lo);
    end
    @(posedge clk);
    if (reset_b) begin
      m_ov = n_ov; m_res = n_res; m_store = n_store; m_wreg = n_wreg; m_ctl = n_ctl;
      m_hi = n_hi; m_lo = n_lo; m_busy_left = n_busy; m_pend_hi = p_hi; m_pend_lo = p_lo;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    eval_check();
    advance();
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; md_op = 0; branch = 0; reg_write = 0; mem_read = 0;
    mem_write = 0; mem_to_reg = 0; exm_we = 0; mwb_we = 0; alu_src1 = 0; alu_src2 = 0;
    sign = 1; alu_fun = AluAdd; shamt = 0; imm = 0; rs = 0; rt = 0; wreg = 0;
    rs_data = 0; rt_data = 0; exm_rd = 0; exm_data = 0; mwb_rd = 0; mwb_data = 0;
    out_ready = 1;
  endtask

  // Run until the offered instruction is accepted (bounded).
  task automatic wait_accept(input string name);
    logic got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      eval_check();
      got = e_acc;
      advance();
    end
    check({name, "_accepted"}, got, 1);
  endtask

  task automatic offer_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    idle();
    in_valid = 1; md_op = op; rs = 1; rt = 2; rs_data = a; rt_data = b;
    reg_write = 1; wreg = 9;
  endtask

  task automatic md_read(input logic [2:0] op, input logic [31:0] exp, input string name);
    offer_md(op, 0, 0);
    wait_accept(name);
    check(name, out_result, exp);
  endtask

  function automatic logic [31:0] pick_data();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(9);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_fun(input int unsigned k);
    case (k)
      0: return AluAdd; 1: return AluSub; 2: return AluAnd; 3: return AluOr;
      4: return AluXor; 5: return AluNor; 6: return AluSlt; 7: return AluSll;
      8: return AluSrl; 9: return AluSra; 10: return AluEq; default: return AluNe;
    endcase
  endfunction

  task automatic randomize_inputs();
    int unsigned r;
    in_valid = ($urandom_range(3) != 0);
    rs = 5'($urandom_range(3)); rt = 5'($urandom_range(3)); wreg = 5'($urandom_range(31));
    rs_data = pick_data(); rt_data = pick_data(); imm = pick_data();
    shamt = 5'($urandom_range(31));
    alu_src1 = ($urandom_range(7) == 0); alu_src2 = ($urandom_range(3) == 0);
    sign = 1'($urandom_range(1)); alu_fun = pick_fun($urandom_range(11));
    r = $urandom_range(15);
    md_op = (r < 9) ? 3'd0 : 3'(r - 8);
    branch = ($urandom_range(3) == 0); reg_write = 1'($urandom_range(1));
    mem_read = 1'($urandom_range(1)); mem_write = 1'($urandom_range(1));
    mem_to_reg = 2'($urandom_range(3)); flush = ($urandom_range(7) == 0);
    exm_rd = 5'($urandom_range(3)); exm_we = 1'($urandom_range(1)); exm_data = pick_data();
    mwb_rd = 5'($urandom_range(3)); mwb_we = 1'($urandom_range(1)); mwb_data = pick_data();
    out_ready = ($urandom_range(3) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    // In reset: an equal-operand branch offer must neither redirect nor be accepted.
    in_valid = 1; branch = 1; alu_fun = AluEq;
    eval_check();
    check("rst_branch_taken", branch_taken, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    advance();
    idle();
    reset_b = 1;

    // EX/MEM forwarding: 7 + 7 = 14; register 0 never forwards: 1 + 1 = 2.
    idle(); in_valid = 1; rs = 3; rt = 3; rs_data = 1; rt_data = 1;
    exm_we = 1; exm_rd = 3; exm_data = 7; reg_write = 1; wreg = 4;
    wait_accept("fwd_exm");
    check("fwd_exm_result", out_result, 32'd14);
    idle(); in_valid = 1; rs = 0; rt = 0; rs_data = 1; rt_data = 1;
    exm_we = 1; exm_rd = 0; exm_data = 7;
    wait_accept("fwd_r0");
    check("fwd_r0_result", out_result, 32'd2);

    // Store data forwarded from MEM/WB over stale rt_data.
    idle(); in_valid = 1; rs = 1; rs_data = 32'h100; rt = 5; rt_data = 32'h1111;
    mwb_we = 1; mwb_rd = 5; mwb_data = 32'hDEAD; alu_src2 = 1; imm = 4; mem_write = 1;
    wait_accept("store");
    check("store_data", out_store, 32'hDEAD);
    check("store_addr", out_result, 32'h104);
    check("store_ctl", out_ctl, 5'b00001);

    // mult -3 x 5, then mflo stalls for the whole iteration.
    offer_md(3'd1, 32'hFFFF_FFFD, 32'd5);
    wait_accept("mult");
    check("mult_ctl", out_ctl, 5'd0);
    begin
      int   stalls;
      logic got;
      stalls = 0; got = 0;
      offer_md(3'd6, 0, 0);
      for (int i = 0; i < 100 && !got; i++) begin
        eval_check();
        if (e_acc) got = 1;
        else stalls++;
        advance();
      end
      check("mflo_accepted", got, 1);
      check("mflo_stall_cycles", stalls, 32);
      check("mult_lo", out_result, 32'hFFFF_FFF1);
    end
    md_read(3'd5, 32'hFFFF_FFFF, "mult_hi");

    // Division corner cases.
    offer_md(3'd3, 32'd7, 32'd0); wait_accept("div0");
    md_read(3'd6, 32'hFFFF_FFFF, "div0_lo");
    md_read(3'd5, 32'd7, "div0_hi");
    offer_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_accept("divovf");
    md_read(3'd6, 32'h8000_0000, "divovf_lo");
    md_read(3'd5, 32'd0, "divovf_hi");
    offer_md(3'd3, 32'hFFFF_FFF9, 32'd2); wait_accept("divneg");
    md_read(3'd6, 32'hFFFF_FFFD, "divneg_lo");
    md_read(3'd5, 32'hFFFF_FFFF, "divneg_hi");

    // Back-pressure: output held, input stalled for 3 cycles, then released.
    idle(); in_valid = 1; rs = 1; rt = 2; rs_data = 10; rt_data = 20;
    wait_accept("bp_first");
    check("bp_first_result", out_result, 32'd30);
    rs_data = 1; rt_data = 2; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      eval_check();
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_result", out_result, 32'd30);
      check("bp_hold_valid", out_valid, 1);
      advance();
    end
    out_ready = 1;
    eval_check();
    check("bp_release_ready", in_ready, 1);
    advance();
    check("bp_second_result", out_result, 32'd3);

    // Taken branch squashes its controls; flushed branch neither redirects nor issues.
    idle(); in_valid = 1; branch = 1; alu_fun = AluEq; rs = 1; rt = 2;
    rs_data = 9; rt_data = 9; reg_write = 1; mem_write = 1;
    eval_check();
    check("beq_taken", branch_taken, 1);
    advance();
    check("beq_valid", out_valid, 1);
    check("beq_ctl", out_ctl, 5'd0);
    flush = 1;
    eval_check();
    check("beq_flush_taken", branch_taken, 0);
    advance();
    check("beq_flush_valid", out_valid, 0);

    // Reset mid-iteration aborts without touching hi/lo.
    offer_md(3'd1, 32'd6, 32'd7); wait_accept("mult_abort");
    idle();
    for (int i = 0; i < 9; i++) cycle();
    reset_b = 0;
    model_reset();
    eval_check();
    check("abort_busy", md_busy, 0);
    advance();
    reset_b = 1;
    md_read(3'd5, 32'd0, "abort_hi");
    md_read(3'd6, 32'd0, "abort_lo");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cycle();
    end
    idle();
    for (int i = 0; i < 40; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
